// File: rtl/instr_fetch_unit.sv
// Fetch stage: one req/ack instruction fetch in flight, a small {pc, instr} buffer toward
// decode, and the PC register write port. Define FETCH_PERF_EN to add push/redirect counters.
module instr_fetch_unit #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_data,
    output logic              pc_write,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    input  logic              id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              pc_write_q, pc_write_d;
    logic [ADDR_W-1:0] pc_data_q, pc_data_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] buf_pc_q    [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc_d    [BUF_DEPTH];
    logic [DATA_W-1:0] buf_instr_q [BUF_DEPTH];
    logic [DATA_W-1:0] buf_instr_d [BUF_DEPTH];
    logic              push;
    logic              pop;
    logic              flush;

    // Control FSM. Issue waits while pc_write_q is high so pc_in already reflects the last update.
    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        pc_write_d  = 1'b0;
        pc_data_d   = pc_data_q;
        push        = 1'b0;
        flush       = 1'b0;
        pop         = (count_q != '0) && id_ready;
        if (redirect) begin
            flush      = 1'b1;
            pop        = 1'b0;
            pc_write_d = 1'b1;
            pc_data_d  = redirect_target - ADDR_W'(1);
            case (state_q)
                S_REQ, S_DRAIN: begin
                    if (imem_ack) begin
                        imem_req_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d    = S_DRAIN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((count_q < FULL_CNT) && !pc_write_q) begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc_in;
                        state_d     = S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        push       = 1'b1;
                        pc_write_d = 1'b1;
                        pc_data_d  = pc_in;
                        imem_req_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        imem_req_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
                default: begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            endcase
        end
    end

    // Fetch buffer: circular, pointers wrap naturally because depth is a power of two.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]    = imem_addr_q;
                buf_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            pc_write_q  <= 1'b0;
            pc_data_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            pc_write_q  <= pc_write_d;
            pc_data_q   <= pc_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign pc_write  = pc_write_q;
    assign pc_data   = pc_data_q;
    assign if_valid  = (count_q != '0);
    assign if_pc     = buf_pc_q[rd_ptr_q];
    assign if_instr  = buf_instr_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (push && (perf_fetch_cnt_q != 32'hFFFF_FFFF)) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end
        if (redirect && (perf_flush_cnt_q != 32'hFFFF_FFFF)) begin
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule
